// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for one shared external combinational ALU.
// Optional performance counters are built only when ALU_ARB_PERF_EN is defined.
module alu_share_arb #(
  parameter int DW    = 32,
  parameter int OPW   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DW-1:0]    req0_a,
  input  logic [DW-1:0]    req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DW-1:0]    req1_a,
  input  logic [DW-1:0]    req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [DW-1:0]    alu_num1,
  output logic [DW-1:0]    alu_num2,
  output logic [OPW-1:0]   alu_op,
  input  logic [DW-1:0]    alu_result,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [DW-1:0]    rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [DW-1:0]    rsp1_result,
  output logic [CNT_W-1:0] perf_acc0,
  output logic [CNT_W-1:0] perf_acc1,
  output logic [CNT_W-1:0] perf_stall
);

  logic           s1_valid_q, s1_valid_d;
  logic           s1_id_q, s1_id_d;
  logic [DW-1:0]  num1_q, num1_d, num2_q, num2_d;
  logic [OPW-1:0] op_q, op_d;
  logic           last_q, last_d;  // id granted most recently
  logic           rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0]  rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;

  logic grant0, grant1, rsp_free, advance, room, acc0, acc1;

  always_comb begin
    grant0   = req0_valid & (~req1_valid | last_q);
    grant1   = req1_valid & (~req0_valid | ~last_q);
    rsp_free = s1_id_q ? (~rsp1_valid_q | rsp1_ready) : (~rsp0_valid_q | rsp0_ready);
    advance  = s1_valid_q & rsp_free;
    room     = ~s1_valid_q | advance;
    // Ready is forced low while reset is held so nothing looks accepted.
    req0_ready = rst_n & grant0 & room;
    req1_ready = rst_n & grant1 & room;
    acc0     = req0_valid & req0_ready;
    acc1     = req1_valid & req1_ready;

    s1_valid_d    = s1_valid_q;
    s1_id_d       = s1_id_q;
    num1_d        = num1_q;
    num2_d        = num2_q;
    op_d          = op_q;
    last_d        = last_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;

    if (rsp0_ready) rsp0_valid_d = 1'b0;
    if (rsp1_ready) rsp1_valid_d = 1'b0;
    if (advance) begin
      s1_valid_d = 1'b0;
      if (s1_id_q) begin
        rsp1_valid_d  = 1'b1;
        rsp1_result_d = alu_result;
      end else begin
        rsp0_valid_d  = 1'b1;
        rsp0_result_d = alu_result;
      end
    end

    if (acc0) begin
      s1_valid_d = 1'b1;
      s1_id_d    = 1'b0;
      num1_d     = req0_a;
      num2_d     = req0_b;
      op_d       = req0_op;
      last_d     = 1'b0;
    end else if (acc1) begin
      s1_valid_d = 1'b1;
      s1_id_d    = 1'b1;
      num1_d     = req1_a;
      num2_d     = req1_b;
      op_d       = req1_op;
      last_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_id_q       <= 1'b0;
      num1_q        <= '0;
      num2_q        <= '0;
      op_q          <= '0;
      last_q        <= 1'b1;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_id_q       <= s1_id_d;
      num1_q        <= num1_d;
      num2_q        <= num2_d;
      op_q          <= op_d;
      last_q        <= last_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
    end
  end

  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_op      = op_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] acc0_cnt_q, acc0_cnt_d, acc1_cnt_q, acc1_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    acc0_cnt_d  = acc0_cnt_q;
    acc1_cnt_d  = acc1_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (acc0 && acc0_cnt_q != '1) acc0_cnt_d = acc0_cnt_q + CNT_W'(1);
    if (acc1 && acc1_cnt_q != '1) acc1_cnt_d = acc1_cnt_q + CNT_W'(1);
    if ((req0_valid | req1_valid) && !(acc0 | acc1) && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0_cnt_q  <= '0;
      acc1_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      acc0_cnt_q  <= acc0_cnt_d;
      acc1_cnt_q  <= acc1_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_acc0  = acc0_cnt_q;
  assign perf_acc1  = acc1_cnt_q;
  assign perf_stall = stall_cnt_q;
`else
  assign perf_acc0  = '0;
  assign perf_acc1  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed steps, then random traffic against per-requester result queues.
module tb_alu_share_arb;
  localparam int DW = 32, OPW = 3, CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0, rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic [DW-1:0] alu_num1, alu_num2, alu_result, rsp0_result, rsp1_result;
  logic [OPW-1:0] alu_op;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [CW-1:0] perf_acc0, perf_acc1, perf_stall;

  always #5 clk = ~clk;

  alu_share_arb #(.DW(DW), .OPW(OPW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .perf_acc0(perf_acc0), .perf_acc1(perf_acc1), .perf_stall(perf_stall));

  // External ALU: 000 and, 001 or, 010 add, 011 xor, 100 shl, 101 shr, 110 sub, 111 signed slt
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OPW-1:0] op);
    case (op)
      3'd0: alu_f = a & b;
      3'd1: alu_f = a | b;
      3'd2: alu_f = a + b;
      3'd3: alu_f = a ^ b;
      3'd4: alu_f = a << b[4:0];
      3'd5: alu_f = a >> b[4:0];
      3'd6: alu_f = a - b;
      default: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_num1, alu_num2, alu_op);

  int checks = 0, passes = 0, fails = 0;
  logic [DW-1:0] q0[$], q1[$];
  int last_win = 1;
  int m_acc0 = 0, m_acc1 = 0, m_stall = 0;
  logic acc0_f, acc1_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, score them, then cross the edge.
  task automatic tick();
    @(negedge clk);
    if (rsp0_valid && rsp0_ready) begin
      check("rsp0_has_entry", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) check("rsp0_result", rsp0_result, q0.pop_front());
    end
    if (rsp1_valid && rsp1_ready) begin
      check("rsp1_has_entry", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) check("rsp1_result", rsp1_result, q1.pop_front());
    end
    acc0_f = req0_valid & req0_ready;
    acc1_f = req1_valid & req1_ready;
    check("one_accept", 32'(acc0_f & acc1_f), 0);
    if (req0_valid && req1_valid && (acc0_f || acc1_f))
      check("rr_winner_is_1", 32'(acc1_f), 32'(last_win == 0));
    if (acc0_f) begin
      q0.push_back(alu_f(req0_a, req0_b, req0_op));
      last_win = 0;
      if (m_acc0 < SAT) m_acc0++;
    end
    if (acc1_f) begin
      q1.push_back(alu_f(req1_a, req1_b, req1_op));
      last_win = 1;
      if (m_acc1 < SAT) m_acc1++;
    end
    if ((req0_valid || req1_valid) && !acc0_f && !acc1_f && m_stall < SAT) m_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(req0_ready), 0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("rst_rsp0_result", rsp0_result, 0);
    check("rst_alu_num1", alu_num1, 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_perf_acc0", 32'(perf_acc0), 0);
    req0_valid = 1'b0;
    rst_n = 1'b1;

    // Single AND on requester 0: one-cycle latency
    req0_valid = 1'b1; req0_a = 32'hF0F000FF; req0_b = 32'h0FF0FF0F; req0_op = 3'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    check("t1_accept", 32'(acc0_f), 1);
    req0_valid = 1'b0;
    check("t1_rsp0_not_yet", 32'(rsp0_valid), 0);
    check("t1_alu_num1", alu_num1, 32'hF0F000FF);
    tick();
    check("t1_rsp0_valid", 32'(rsp0_valid), 1);
    check("t1_rsp0_result", rsp0_result, 32'h00F0000F);
    check("t1_rsp1_idle", 32'(rsp1_valid), 0);
    tick();
    check("t1_rsp0_popped", 32'(rsp0_valid), 0);

    // Signed set-less-than on requester 1
    req1_valid = 1'b1; req1_op = 3'd7; req1_a = 32'd2; req1_b = 32'd9;
    tick();
    check("t4_accept_a", 32'(acc1_f), 1);
    req1_a = 32'd9; req1_b = 32'd2;
    tick();
    check("t4_accept_b", 32'(acc1_f), 1);
    check("t4_slt_true", rsp1_result, 32'd1);
    req1_valid = 1'b0;
    tick();
    check("t4_slt_false", rsp1_result, 32'd0);
    tick();

    // Both requesters streaming: grants alternate starting with 0
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'd3; req0_b = 32'd4;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 32'd5; req1_b = 32'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_grant0", 32'(acc0_f), 32'(i % 2 == 0));
      check("t2_grant1", 32'(acc1_f), 32'(i % 2 == 1));
      if (i == 1) check("t2_add", rsp0_result, 32'h00000007);
      if (i == 2) check("t2_sub", rsp1_result, 32'hFFFFFFFE);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    // Backpressure on response 0
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'd10; req0_b = 32'd1;
    tick();
    check("t3_acc_first", 32'(acc0_f), 1);
    req0_a = 32'd20; req0_b = 32'd2;
    tick();
    check("t3_acc_second", 32'(acc0_f), 1);
    req0_a = 32'd30; req0_b = 32'd3;
    #1;
    check("t3_ready_blocked", 32'(req0_ready), 0);
    check("t3_rsp0_held", rsp0_result, 32'd11);
    tick();
    check("t3_still_blocked", 32'(acc0_f), 0);
    rsp0_ready = 1'b1;
    tick();
    check("t3_acc_after_drain", 32'(acc0_f), 1);
    req0_valid = 1'b0;
    repeat (3) tick();
    check("t3_all_delivered", 32'(q0.size()), 0);
    check("t3_rsp0_empty", 32'(rsp0_valid), 0);

    // Reset while s1 and response 1 are both occupied
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 32'd1; req1_b = 32'd1;
    tick();
    req1_a = 32'd2;
    tick();
    req1_valid = 1'b0;
    check("t5_rsp1_full", 32'(rsp1_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rsp1_valid", 32'(rsp1_valid), 0);
    check("t5_rsp1_result", rsp1_result, 0);
    check("t5_alu_num1", alu_num1, 0);
    check("t5_alu_num2", alu_num2, 0);
    check("t5_alu_op", 32'(alu_op), 0);
    q0.delete(); q1.delete();
    last_win = 1; m_acc0 = 0; m_acc1 = 0; m_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'h10; req0_b = 32'h01;
    req1_valid = 1'b1; req1_op = 3'd3; req1_a = 32'h55; req1_b = 32'hFF;
    #1;
    check("t5_req0_first", 32'(req0_ready), 1);
    check("t5_req1_waits", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b0;
    repeat (3) tick();

    // Random traffic with random backpressure
    for (int c = 0; c < 500; c++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = OPW'($urandom_range(0, 7));
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = OPW'($urandom_range(0, 7));
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc0_f) req0_valid = 1'b0;
      if (acc1_f) req1_valid = 1'b0;
    end
    if (req0_valid || req1_valid) begin
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int n = 0; n < 10 && (req0_valid || req1_valid); n++) begin
        tick();
        if (acc0_f) req0_valid = 1'b0;
        if (acc1_f) req1_valid = 1'b0;
      end
    end
    check("rand_req0_accepted", 32'(req0_valid), 0);
    check("rand_req1_accepted", 32'(req1_valid), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int n = 0; n < 50 && (q0.size() > 0 || q1.size() > 0 || rsp0_valid || rsp1_valid); n++) tick();
    check("drain_q0", 32'(q0.size()), 0);
    check("drain_q1", 32'(q1.size()), 0);

`ifdef ALU_ARB_PERF_EN
    check("perf_acc0", 32'(perf_acc0), 32'(m_acc0));
    check("perf_acc1", 32'(perf_acc1), 32'(m_acc1));
    check("perf_stall", 32'(perf_stall), 32'(m_stall));
`else
    check("perf_acc0_tied", 32'(perf_acc0), 0);
    check("perf_acc1_tied", 32'(perf_acc1), 0);
    check("perf_stall_tied", 32'(perf_stall), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational ALU instance between two requesters, e.g. a main issue port and a branch/address-compute port.
- Arbitrates round-robin and registers the operands into a single operand stage that drives the ALU.
- Captures the ALU result into a per-requester response register with valid/ready handshake.
- Sits between the issue logic and the external ALU; the ALU itself stays outside the block.

Parameters:
- DW, 32, operand/result width.
- OPW, 3, ALU opcode width.
- CNT_W, 16, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  DW  operand 1.
- req0_b  in  DW  operand 2.
- req0_op  in  OPW  ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_num1  out  DW  registered operand 1 to the ALU.
- alu_num2  out  DW  registered operand 2 to the ALU.
- alu_op  out  OPW  registered opcode to the ALU.
- alu_result  in  DW  combinational ALU result.
- rsp0_valid  out  1  response 0 holds a result.
- rsp0_ready  in  1  consumer 0 takes the result.
- rsp0_result  out  DW  result for requester 0.
- rsp1_valid, rsp1_ready, rsp1_result: same as response 0, for requester 1.
- perf_acc0  out  CNT_W  accepted operations, requester 0.
- perf_acc1  out  CNT_W  accepted operations, requester 1.
- perf_stall  out  CNT_W  cycles with a valid request but no accept.

Behaviour:
- Reset is asynchronous on rst_n low. All of the following clear to 0: req*_ready, rsp*_valid, rsp*_result, alu_num1/num2/op, stage valid, stage id, perf counters. The round-robin pointer resets so that requester 0 wins first.
- Reset mid-operation discards any staged or unconsumed results; nothing is replayed.
- Requester rules:
  - valid must not depend on ready.
  - Once valid is high, a/b/op stay stable until accepted.
  - Transfer occurs at a rising edge with valid & ready both high.
- Grant (combinational):
  - Only one requester valid: it is granted.
  - Both valid: the one not granted most recently is granted.
  - The pointer updates only on an accept.
- Operand stage (s1): holds s1_valid, s1_id, and operands that drive alu_*.
  - s1 advances when s1_valid and (rsp[s1_id]_valid == 0 or rsp[s1_id]_ready == 1).
  - reqX_ready = grantX & (~s1_valid | advance).
  - Ready therefore may combinationally depend on rspX_ready.
  - On accept: s1 loads the winner's a/b/op and id; s1_valid is set.
  - When s1 advances without a new accept, s1_valid clears. alu_* hold their last values while s1_valid is 0.
- Response register: on advance, rsp[s1_id]_result <= alu_result and rsp[s1_id]_valid <= 1. rspX_valid clears on rspX_ready when not reloaded in the same cycle.
- Simultaneous pop and reload on the same response keeps valid at 1 with the new result.
- Latency: accept at edge N → rspX_valid high after edge N+1, provided no backpressure.
- Throughput: 1 operation/cycle total when the responses are drained.
- A blocked response stalls s1 only; the other requester cannot overtake through s1 (in-order, single stage).
- Arithmetic is performed entirely by the external ALU; the block passes width DW unchanged.

Optional Feature:
- Macro ALU_ARB_PERF_EN.
- Defined:
  - perf_acc0/perf_acc1 increment on each accept for that requester.
  - perf_stall increments each cycle where (req0_valid | req1_valid) and no accept occurs.
  - All counters saturate at 2^CNT_W-1 and clear only on reset.
- Not defined: counter logic is absent and the perf_* ports are tied to 0.

Test Plan:
- req0 op=000, a=0xF0F000FF, b=0x0FF0FF0F, rsp0_ready=1 → rsp0_valid one cycle after the accept edge, rsp0_result=0x00F0000F; rsp1_valid stays 0.
- Both requesters valid for 4 cycles (req0 op=010 3+4, req1 op=110 5-7) → grants alternate 0,1,0,1; results 0x00000007 and 0xFFFFFFFE return to the correct response ports.
- rsp0_ready=0, req0 issues two ops → first lands in rsp0, second held in s1, req0_ready low. Raise rsp0_ready → both delivered in order, no loss or duplication.
- req1 op=111, a=2, b=9 → rsp1_result=1; a=9, b=2 → rsp1_result=0.
- Assert rst_n=0 while s1_valid=1 and rsp1_valid=1 → all valids and outputs 0 immediately; after release, requester 0 wins the first simultaneous request.
- With ALU_ARB_PERF_EN: 3 req0 accepts, 2 req1 accepts, 4 blocked cycles → perf_acc0=3, perf_acc1=2, perf_stall=4. Force 0xFFFF then one more event → counter holds 0xFFFF.
